// File: rtl/filter2d_conv.sv
// filter2d_conv: streaming KxK valid-window convolution with runtime kernel, frame-synchronous commit and saturation.
// Optional FILTER2D_ROUND_EN: round half up before the shift instead of truncating.
module filter2d_conv #(
    parameter int FRAME_H    = 1080,
    parameter int FRAME_W    = 1920,
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 10,
    parameter int COEF_WIDTH = 8,
    parameter int WIN_SIZE   = 3,
    parameter int FOUT_SHIFT = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    input  logic                                   s_sof,
    input  logic [DIN_WIDTH-1:0]                   s_data,
    input  logic                                   coef_we,
    input  logic [$clog2(WIN_SIZE*WIN_SIZE)-1:0]   coef_addr,
    input  logic [COEF_WIDTH-1:0]                  coef_data,
    output logic                                   m_valid,
    output logic                                   m_sof,
    output logic                                   m_eol,
    output logic [DOUT_WIDTH-1:0]                  m_data
);
    localparam int K   = WIN_SIZE;
    localparam int KK  = K * K;
    localparam int AW  = $clog2(KK);
    localparam int XW  = $clog2(FRAME_W);
    localparam int YW  = $clog2(FRAME_H);
    localparam int PW  = DIN_WIDTH + COEF_WIDTH;
    localparam int SW  = PW + $clog2(KK);
    localparam int RW  = SW + 1;
    localparam int CTR = (KK - 1) / 2;
    localparam logic [COEF_WIDTH-1:0] ID_COEF = COEF_WIDTH'(1 << FOUT_SHIFT);
    localparam logic [RW-1:0] MAXV = RW'((1 << DOUT_WIDTH) - 1);
`ifdef FILTER2D_ROUND_EN
    localparam logic [RW-1:0] RND = (RW'(1) << FOUT_SHIFT) >> 1;
`else
    localparam logic [RW-1:0] RND = '0;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [XW-1:0]          x, cx;
    logic [YW-1:0]          y, cy;
    logic                   sof_in, accept, wvalid;
    logic [DIN_WIDTH-1:0]   lb [K-1][FRAME_W];
    logic [DIN_WIDTH-1:0]   win [K][K];
    logic [COEF_WIDTH-1:0]  shadow [KK];
    logic [COEF_WIDTH-1:0]  kern [KK];
    logic [PW-1:0]          prod [KK];
    logic                   v1, v2, sof1, sof2, eol1, eol2;
    logic [RW-1:0]          acc, res;

    // Accept/position decode: an sof pixel is always taken as (0,0)
    always_comb begin
        sof_in = s_valid && s_sof;
        accept = s_valid && (s_sof || state == ACTIVE);
        cx     = sof_in ? '0 : x;
        cy     = sof_in ? '0 : y;
        wvalid = accept && cx >= XW'(K - 1) && cy >= YW'(K - 1);
    end

    // Frame FSM and raster counters; x/y hold the position of the next pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else if (accept) begin
            if (cx == XW'(FRAME_W - 1)) begin
                x <= '0;
                if (cy == YW'(FRAME_H - 1)) begin
                    y     <= '0;
                    state <= IDLE;
                end else begin
                    y     <= cy + YW'(1);
                    state <= ACTIVE;
                end
            end else begin
                x     <= cx + XW'(1);
                y     <= cy;
                state <= ACTIVE;
            end
        end
    end

    // Kernel banks: shadow takes writes, active snapshots the old shadow on each accepted sof
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) begin
                shadow[i] <= (i == CTR) ? ID_COEF : '0;
                kern[i]   <= (i == CTR) ? ID_COEF : '0;
            end
        end else begin
            if (accept && s_sof)
                for (int i = 0; i < KK; i++) kern[i] <= shadow[i];
            if (coef_we && coef_addr < AW'(KK))
                shadow[coef_addr] <= coef_data;
        end
    end

    // Line buffers cascade column-wise: lb[j] holds the line j+1 above the current one
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][cx] <= s_data;
            for (int j = 1; j < K - 1; j++) lb[j][cx] <= lb[j-1][cx];
        end
    end

    // Window shifts left; new rightmost column is buffered lines on top, live pixel at bottom
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
            for (int r = 0; r < K - 1; r++) win[r][K-1] <= lb[K-2-r][cx];
            win[K-1][K-1] <= s_data;
        end
    end

    // Stage 2: per-tap products against the active kernel
    always_ff @(posedge clk) begin
        for (int i = 0; i < KK; i++) prod[i] <= PW'(kern[i]) * PW'(win[i / K][i % K]);
    end

    // Adder tree with optional rounding offset, then shift
    always_comb begin
        acc = RND;
        for (int i = 0; i < KK; i++) acc = acc + RW'(prod[i]);
        res = acc >> FOUT_SHIFT;
    end

    // Valid/marker pipeline and saturating output register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            sof1    <= 1'b0;
            sof2    <= 1'b0;
            eol1    <= 1'b0;
            eol2    <= 1'b0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_data  <= '0;
        end else begin
            v1      <= wvalid;
            sof1    <= wvalid && cx == XW'(K - 1) && cy == YW'(K - 1);
            eol1    <= wvalid && cx == XW'(FRAME_W - 1);
            v2      <= v1;
            sof2    <= sof1;
            eol2    <= eol1;
            m_valid <= v2;
            m_sof   <= sof2;
            m_eol   <= eol2;
            m_data  <= (res > MAXV) ? '1 : res[DOUT_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_filter2d_conv.sv
// tb_filter2d_conv: randomized self-checking bench against a frame-image reference model.
module tb_filter2d_conv;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int SH = 6;
`ifdef FILTER2D_ROUND_EN
    localparam int RND = 32;
`else
    localparam int RND = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, s_valid, s_sof, coef_we;
    logic [7:0] s_data, coef_data;
    logic [3:0] coef_addr;
    logic       m_valid, m_sof, m_eol;
    logic [9:0] m_data;

    always #5 clk = ~clk;

    filter2d_conv #(.FRAME_H(H), .FRAME_W(W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data)
    );

    typedef struct {int due; int data; bit sof; bit eol;} exp_t;

    int   img [H][W];
    int   shadow [9];
    int   kern [9];
    bit   mact;
    int   mx, my, cyc, n_cmp, n_err, n_out, last_data;
    exp_t q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) begin
            shadow[i] = (i == 4) ? 64 : 0;
            kern[i]   = (i == 4) ? 64 : 0;
        end
        mact = 0;
        mx   = 0;
        my   = 0;
        q.delete();
    endfunction

    task automatic step(input bit rs, input bit sv, input bit sof, input int d,
                        input bit we, input int a, input int cd);
        int   s;
        exp_t e;
        rst = rs; s_valid = sv; s_sof = sof; s_data = 8'(d);
        coef_we = we; coef_addr = 4'(a); coef_data = 8'(cd);
        @(posedge clk);
        cyc++;
        if (rs) model_reset();
        else begin
            if (sv && (sof || mact)) begin
                if (sof) begin
                    mx = 0; my = 0;
                    kern = shadow;
                end
                img[my][mx] = d;
                if (mx >= K - 1 && my >= K - 1) begin
                    s = 0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            s += kern[r*K+c] * img[my-K+1+r][mx-K+1+c];
                    s = (s + RND) >> SH;
                    if (s > 1023) s = 1023;
                    q.push_back('{due: cyc + 2, data: s, sof: (mx == K-1 && my == K-1), eol: (mx == W-1)});
                end
                mact = 1;
                if (mx == W - 1) begin
                    mx = 0;
                    if (my == H - 1) begin
                        my = 0;
                        mact = 0;
                    end else my++;
                end else mx++;
            end
            if (we && a < 9) shadow[a] = cd;
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("valid", int'(m_valid), 1);
            check("data", int'(m_data), e.data);
            check("sof", int'(m_sof), int'(e.sof));
            check("eol", int'(m_eol), int'(e.eol));
            n_out++;
            last_data = int'(m_data);
        end else check("valid_idle", int'(m_valid), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wcoef(input int a, input int v);
        step(0, 0, 0, 0, 1, a, v);
    endtask

    // mode 0: constant cval, 1: ramp x+5y, 2: random; coef write of (wa,wv) rides on pixel index wi
    task automatic send_frame(input int mode, input int cval, input int gap, input int npix,
                              input int wi, input int wa, input int wv);
        int d, idx;
        idx = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                if (idx < npix) begin
                    if (gap > 0) idle($urandom_range(0, gap));
                    d = (mode == 0) ? cval : (mode == 1) ? xx + 5 * yy : int'($urandom_range(0, 255));
                    step(0, 1, idx == 0, d, idx == wi, wa, wv);
                end
                idx++;
            end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_out = 0; cyc = 0; last_data = -1;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 7, 0, 0, 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_sof", int'(m_sof), 0);
        check("rst_eol", int'(m_eol), 0);
        check("rst_data", int'(m_data), 0);

        for (int i = 0; i < 4; i++) step(0, 1, 0, 99, 0, 0, 0);
        n_out = 0;
        send_frame(0, 100, 0, W * H, -1, 0, 0);
        idle(4);
        check("t1_count", n_out, 6);
        check("t1_last", last_data, 100);

        for (int i = 0; i < 9; i++) wcoef(i, 255);
        send_frame(0, 255, 0, W * H, -1, 0, 0);
        idle(4);
        check("t2_sat", last_data, 1023);

        wcoef(0, 64);
        for (int i = 1; i < 9; i++) wcoef(i, 0);
        wcoef(12, 200);
        send_frame(1, 0, 0, W * H, -1, 0, 0);
        idle(4);
        check("t3_ramp", last_data, 7);

        step(1, 0, 0, 0, 0, 0, 0);
        send_frame(0, 100, 0, W * H, 10, 4, 32);
        idle(4);
        check("t4_cur", last_data, 100);
        send_frame(0, 100, 0, W * H, 0, 4, 64);
        idle(4);
        check("t4_next", last_data, 50);
        send_frame(0, 100, 0, W * H, -1, 0, 0);
        idle(4);
        check("t4_defer", last_data, 100);

        step(1, 0, 0, 0, 0, 0, 0);
        wcoef(4, 32);
        send_frame(0, 1, 0, W * H, -1, 0, 0);
        idle(4);
        check("t5_round", last_data, RND > 0 ? 1 : 0);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 9; i++) wcoef(i, $urandom_range(0, 15));
            send_frame(2, 0, 3, W * H, -1, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 1, 0, $urandom_range(0, 255), 0, 0, 0);
            send_frame(2, 0, 2, 13 + $urandom_range(0, 4), $urandom_range(0, 12), $urandom_range(0, 9), $urandom_range(0, 15));
            send_frame(2, 0, 2, W * H, -1, 0, 0);
            send_frame(2, 0, 1, 13 + $urandom_range(0, 4), -1, 0, 0);
            step(1, 0, 0, 0, 0, 0, 0);
            idle(3);
            send_frame(2, 0, 2, W * H, -1, 0, 0);
            idle(4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/filter2d_conv.md
# filter2d_conv

Streaming 2D convolution core, next generation of the fixed-kernel 3x3 filter: generic odd window size, runtime-loadable kernel with frame-synchronous commit, and saturating output. Sits between the video input formatter and the output packer; consumes one raster pixel per valid cycle, no backpressure. Emits one result per window fully inside the frame ("valid" convolution), so the output frame is (FRAME_H-WIN_SIZE+1) x (FRAME_W-WIN_SIZE+1).

## Interface
- FRAME_H, 1080, input frame height in lines
- FRAME_W, 1920, input frame width in pixels (>= WIN_SIZE)
- DIN_WIDTH, 8, input pixel width
- DOUT_WIDTH, 10, output pixel width
- COEF_WIDTH, 8, unsigned coefficient width
- WIN_SIZE, 3, window edge K; odd, 3..7
- FOUT_SHIFT, 6, right shift applied to the accumulated sum
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- s_valid  in  1  input pixel valid
- s_sof  in  1  start of frame, qualified by s_valid
- s_data  in  DIN_WIDTH  input pixel
- coef_we  in  1  kernel shadow write strobe
- coef_addr  in  $clog2(K*K)  coefficient index, row-major, 0 = top-left
- coef_data  in  COEF_WIDTH  coefficient value
- m_valid  out  1  output valid
- m_sof  out  1  first output pixel of frame
- m_eol  out  1  last output pixel of an output line
- m_data  out  DOUT_WIDTH  filtered pixel

## Operation
- Counters x (0..FRAME_W-1), y (0..FRAME_H-1) track the accepted pixel. A pixel with s_valid&s_sof is accepted as x=0,y=0, regardless of state (mid-frame sof restarts the frame).
- State IDLE: s_valid pixels without s_sof dropped. sof -> ACTIVE.
- ACTIVE: each s_valid pixel accepted; x increments, wraps to 0 with y+1. Pixel (W-1,H-1) accepted -> IDLE.
- K-1 line buffers of FRAME_W x DIN_WIDTH plus a KxK window register. Line buffer contents are not reset; outputs relying on them are suppressed by the window-valid rule.
- Window valid when accepted pixel has x>=K-1 and y>=K-1; that pixel is the window's bottom-right.
- sum = Σ coef[i]*pix[i], width DIN_WIDTH+COEF_WIDTH+$clog2(K*K), unsigned, no overflow. result = sum >> FOUT_SHIFT; if result > 2^DOUT_WIDTH-1, m_data = 2^DOUT_WIDTH-1.
- Kernel: shadow bank written by coef_we at coef_addr; active bank loaded from shadow on each accepted sof pixel. The sof pixel's window (and all of that frame) uses the new kernel. coef_we in the same cycle as the commit lands in shadow only; it takes effect next sof. coef_addr >= K*K ignored.
- Reset: both banks = identity (center coefficient 2^FOUT_SHIFT, rest 0); state IDLE; x=y=0.
- m_sof on output for window at (K-1,K-1); m_eol on windows with x=W-1.

## Timing
- Latency 3 cycles: window whose bottom-right pixel is accepted at cycle t appears on m_* at t+3 (stage 1 window/line-buffer update, stage 2 products, stage 3 adder tree + shift + saturate, registered).
- Pipeline advances every cycle; in-flight results drain even if s_valid drops or state returns to IDLE.
- Reset outputs: m_valid=0, m_sof=0, m_eol=0, m_data=0. rst mid-frame flushes the pipeline: no m_valid until a new window forms after the next sof.
- Mid-frame sof: in-flight results of the old frame still emit; new-frame outputs start K-1 lines later.

## Configuration
- FILTER2D_ROUND_EN defined: result = (sum + 2^(FOUT_SHIFT-1)) >> FOUT_SHIFT (round half up; no-op when FOUT_SHIFT=0), before saturation. Not defined: truncation.

## Test plan
- FRAME_W=5, FRAME_H=4, K=3, reset kernel, all pixels 100 -> exactly 6 outputs of 100, m_sof on first, m_eol on 3rd and 6th, each 3 cycles after its bottom-right pixel.
- All pixels 255, all 9 coefficients 255 written then sof -> every output 1023 (sum 585225>>6=9144 saturated).
- Ramp pixel = x+5y, coef[0]=64 others 0 -> output at window bottom-right (x,y) equals (x-2)+5(y-2); proves top-left alignment and line buffering.
- Write coef[4]=32 mid-frame -> current frame unchanged (100); next frame 50; write in sof cycle -> deferred one frame.
- Pixels 1, center coef 32, FOUT_SHIFT=6 -> 0 without FILTER2D_ROUND_EN, 1 with it.
- s_valid gaps of random length, mid-frame sof, and rst asserted mid-frame -> output values/count match model; no m_valid between rst and first window of next frame.
